// File: rtl/risc_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
// The optional checksum trailer is controlled by the LOADER_CHECKSUM_EN macro.
package risc_pkg;

    localparam int ADDR_W     = 6;
    localparam int WORD_W     = 24;
    localparam int BYTE_W     = 8;
    localparam int LEN_W      = ADDR_W + 1;
    localparam int IMEM_DEPTH = 1 << ADDR_W;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

    function automatic logic len_is_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= MAX_LEN);
    endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Packs three accepted stream bytes, big-endian, into one instruction word.
// o_word is only meaningful in the cycle o_word_ready is high.
module loader_byte_packer
    import risc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready
);

    logic [1:0]               r_cnt;
    // Only the first two bytes need storing; the third is taken live from i_byte.
    logic [WORD_W-BYTE_W-1:0] r_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 2'd0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_cnt   <= 2'd0;
        end else if (i_accept) begin
            r_cnt   <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_accept && (r_cnt == 2'd2);

endmodule

// File: rtl/program_loader.sv
// Streams a program into instruction memory and holds the core in reset until
// a complete, clean load. Optional checksum trailer: define LOADER_CHECKSUM_EN.
module program_loader
    import risc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_byte_valid,
    input  logic [BYTE_W-1:0] i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_wr,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [WORD_W-1:0] o_imem_data,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    loader_state_t     r_state, w_state_next;
    logic [LEN_W-1:0]  r_len, w_len_next;
    logic              r_byte_ready, w_byte_ready_next;
    logic              r_imem_wr, w_imem_wr_next;
    logic [ADDR_W-1:0] r_imem_addr, w_imem_addr_next;
    logic [WORD_W-1:0] r_imem_data, w_imem_data_next;
    logic              r_cpu_reset, w_cpu_reset_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;

    logic              w_accept;
    logic              w_pack_accept;
    logic              w_clr;
    logic [WORD_W-1:0] w_word;
    logic              w_word_ready;
    logic              w_last_word;

    // READY is high in both RECV and CHECK; only RECV bytes are payload.
    assign w_accept      = i_byte_valid && r_byte_ready;
    assign w_pack_accept = w_accept && (r_state == ST_RECV);
    assign w_last_word   = (({1'b0, r_imem_addr} + LEN_W'(1)) == r_len);

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_sum, w_sum_next;
`endif

    loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (w_clr),
        .i_accept     (w_pack_accept),
        .i_byte       (i_byte_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_byte_ready <= 1'b0;
            r_imem_wr    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_len        <= w_len_next;
            r_byte_ready <= w_byte_ready_next;
            r_imem_wr    <= w_imem_wr_next;
            r_imem_addr  <= w_imem_addr_next;
            r_imem_data  <= w_imem_data_next;
            r_cpu_reset  <= w_cpu_reset_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_err        <= w_err_next;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sum <= '0;
        else          r_sum <= w_sum_next;
    end
`endif

    always_comb begin
        w_state_next      = r_state;
        w_len_next        = r_len;
        w_byte_ready_next = 1'b0;
        w_imem_wr_next    = 1'b0;
        w_imem_addr_next  = r_imem_addr;
        w_imem_data_next  = r_imem_data;
        w_cpu_reset_next  = r_cpu_reset;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_err_next        = r_err;
        w_clr             = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        w_sum_next        = r_sum;
`endif

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    if (len_is_legal(i_len)) begin
                        w_state_next      = ST_RECV;
                        w_len_next        = i_len;
                        w_imem_addr_next  = '0;
                        w_byte_ready_next = 1'b1;
                        w_cpu_reset_next  = 1'b1;
                        w_busy_next       = 1'b1;
                        w_done_next       = 1'b0;
                        w_err_next        = 1'b0;
                        w_clr             = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        w_sum_next        = '0;
`endif
                    end else begin
                        w_state_next     = ST_DONE;
                        w_cpu_reset_next = 1'b1;
                        w_busy_next      = 1'b0;
                        w_done_next      = 1'b1;
                        w_err_next       = 1'b1;
                    end
                end
            end

            ST_RECV: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_pack_accept) w_sum_next = r_sum + i_byte_data;
`endif
                if (w_word_ready) begin
                    w_state_next     = ST_WRITE;
                    w_imem_wr_next   = 1'b1;
                    w_imem_data_next = w_word;
                end else begin
                    w_byte_ready_next = 1'b1;
                end
            end

            ST_WRITE: begin
                // Address only advances when another word follows, so it never wraps.
                if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_next      = ST_CHECK;
                    w_byte_ready_next = 1'b1;
`else
                    w_state_next     = ST_DONE;
                    w_cpu_reset_next = 1'b0;
                    w_busy_next      = 1'b0;
                    w_done_next      = 1'b1;
                    w_err_next       = 1'b0;
`endif
                end else begin
                    w_state_next      = ST_RECV;
                    w_imem_addr_next  = r_imem_addr + ADDR_W'(1);
                    w_byte_ready_next = 1'b1;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    w_state_next     = ST_DONE;
                    w_busy_next      = 1'b0;
                    w_done_next      = 1'b1;
                    w_err_next       = (i_byte_data != r_sum);
                    w_cpu_reset_next = (i_byte_data != r_sum);
                end else begin
                    w_byte_ready_next = 1'b1;
                end
            end
`endif

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_byte_ready = r_byte_ready;
    assign o_imem_wr    = r_imem_wr;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_data  = r_imem_data;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
